// File: rtl/module_timer_sched_pkg.sv
// Shared types and sizing helpers for the timer scheduler.
// Provides the FSM state enum, a minimum-1 clog2 helper and default sizes
// (prescaler counter width and requester index width for the default build).
package pkg_timer_sched;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter/index widths never collapse to zero bits, even for n <= 2.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int NREQ_DEFAULT  = 4;
  localparam int W_DEFAULT     = 8;
  localparam int PRESC_DEFAULT = 1000;

  localparam int PRESC_W = clog2_min1(PRESC_DEFAULT);
  localparam int IDX_W   = clog2_min1(NREQ_DEFAULT);

endpackage

// File: rtl/module_timer_sched_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Ports: req (request levels), last (previous owner index) -> valid (any
// request), grant (one-hot winner), idx (winner index). Search starts at last+1.
module module_rr_arbiter
  import pkg_timer_sched::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Walk last+1 .. last+NREQ (mod NREQ); the first set request wins, so the
  // previous owner is considered last.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    idx   = '0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last) + i) % NREQ);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/module_timer_sched.sv
// Shared delay timer: round-robin grant, load delay, count ticks, pulse done.
// Ports: clk, rst (sync active-low), req/delay per requester in; gnt, done
// (registered one-hot), busy, tick (prescaler pulse), cnt (remaining ticks) out.
module module_timer_sched
  import pkg_timer_sched::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int W     = W_DEFAULT,
  parameter int PRESC = PRESC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] delay,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              tick,
  output logic [W-1:0]      cnt
);

  localparam int PW = clog2_min1(PRESC);
  localparam int IW = clog2_min1(NREQ);

  state_t          state;
  logic [PW-1:0]   presc;
  logic [IW-1:0]   last;
  logic [IW-1:0]   own;
  logic            arb_vld;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            own_req;
  logic            presc_wrap;

  module_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .last  (last),
    .valid (arb_vld),
    .grant (arb_gnt),
    .idx   (arb_idx)
  );

  assign own_req    = req[own];
  assign presc_wrap = (presc == PW'(PRESC - 1));

  // Tick only fires on the RUN branch that actually decrements: owner still
  // requesting and count not yet exhausted.
  assign tick = (state == RUN) && own_req && (cnt != '0) && presc_wrap;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      cnt   <= '0;
      presc <= '0;
      last  <= IW'(NREQ - 1);
      own   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_vld) begin
            state <= RUN;
            gnt   <= arb_gnt;
            own   <= arb_idx;
            cnt   <= delay[arb_idx*W +: W];
            presc <= '0;
          end
        end
        RUN: begin
          if (!own_req) begin
            // Owner abandoned the wait: release silently, rotate past it.
            state <= IDLE;
            gnt   <= '0;
            last  <= own;
            cnt   <= '0;
            presc <= '0;
          end else if (cnt == '0) begin
            state <= DONE;
            done  <= gnt;
          end else if (presc_wrap) begin
            presc <= '0;
            cnt   <= cnt - W'(1);
          end else begin
            presc <= presc + PW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= '0;
          gnt   <= '0;
          last  <= own;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          done  <= '0;
        end
      endcase
    end
  end

endmodule
